// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache write buffer.
package dcache_pkg;

    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 16;

    // Clears the byte offset within a cache line (16 words x 4 bytes = 64 bytes).
    localparam logic [DEF_ADDR_W-1:0] LINE_OFF_MASK =
        ~(DEF_ADDR_W'(DEF_LINE_WORDS * (DEF_DATA_W / 8) - 1));

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        DRAIN,
        READ,
        RESP
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular store buffer: head/tail pointers wrap modulo DEPTH, count has one
// extra bit so full and empty are distinguishable. The youngest entry can be
// read and have its data overwritten in place (used for store merging).
module wb_fifo
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  wb_entry_t               push_entry,
    input  logic                    pop,
    input  logic                    ovr,
    input  logic [DEF_DATA_W-1:0]   ovr_data,
    output wb_entry_t               head_entry,
    output wb_entry_t               young_entry,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [PTR_W-1:0]   young;

    assign young       = tail - 1'b1;
    assign head_entry  = mem[head];
    assign young_entry = mem[young];
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);

    // Storage: new entries land at tail; a merge rewrites the youngest data.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= push_entry;
        if (ovr)
            mem[young].data <= ovr_data;
    end

    // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/dcache_write_buffer.sv
// Data-cache write buffer: queues word stores, drains them to DM one at a
// time and orders line refills behind the stores pending at request time.
// Optional store merging into the youngest entry: define DCACHE_WB_MERGE_EN.
module dcache_write_buffer
    import dcache_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_write_i,
    input  logic [ADDR_W-1:0]            wb_address_i,
    input  logic [DATA_W-1:0]            wb_data_i,
    output logic                         wb_full_o,
    input  logic                         line_read_i,
    input  logic [ADDR_W-1:0]            line_address_i,
    output logic [LINE_WORDS*DATA_W-1:0] line_data_o,
    output logic                         line_valid_o,
    output logic                         dm_write_o,
    output logic                         dm_read_o,
    output logic [ADDR_W-1:0]            dm_address_o,
    output logic [DATA_W-1:0]            dm_data_o,
    input  logic [LINE_WORDS*DATA_W-1:0] dm_data_i,
    input  logic                         dm_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_e          state, state_nx;
    logic [CNT_W-1:0]   drain_left, drain_left_nx;
    logic [CNT_W-1:0]   count;
    logic               fifo_full, fifo_empty;
    logic               push, pop, merge_hit;
    wb_entry_t          head_entry, young_entry, push_entry;

    assign wb_full_o  = fifo_full;
    assign push_entry = '{addr: DEF_ADDR_W'(wb_address_i), data: DEF_DATA_W'(wb_data_i)};

`ifdef DCACHE_WB_MERGE_EN
    logic head_busy;
    // The head is on the DM bus in WRITE/DRAIN; when it is also the youngest
    // entry its data must not change under the pending DM write.
    assign head_busy = ((state == WRITE) || (state == DRAIN)) && (count == CNT_W'(1));
    assign merge_hit = wb_write_i && !fifo_empty && !head_busy &&
                       (young_entry.addr == DEF_ADDR_W'(wb_address_i));
`else
    logic young_unused;
    // Without merging the youngest-entry view has no consumer.
    assign young_unused = ^young_entry;
    assign merge_hit    = 1'b0;
`endif

    // A merge absorbs the store even when full; otherwise full drops it.
    assign push = wb_write_i && !merge_hit && !fifo_full;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .ovr         (merge_hit),
        .ovr_data    (DEF_DATA_W'(wb_data_i)),
        .head_entry  (head_entry),
        .young_entry (young_entry),
        .count       (count),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // State, drain budget and the captured refill line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            drain_left  <= '0;
            line_data_o <= '0;
        end else begin
            state      <= state_nx;
            drain_left <= drain_left_nx;
            if (state == READ && dm_ready_i)
                line_data_o <= dm_data_i;
        end
    end

    // Next state and DM handshake; at most one DM request is driven at a time.
    always_comb begin
        state_nx      = state;
        drain_left_nx = drain_left;
        pop           = 1'b0;
        dm_write_o    = 1'b0;
        dm_read_o     = 1'b0;
        dm_address_o  = '0;
        dm_data_o     = '0;
        line_valid_o  = 1'b0;
        case (state)
            IDLE: begin
                if (line_read_i && !fifo_empty) begin
                    // Only stores already queued precede this refill.
                    state_nx      = DRAIN;
                    drain_left_nx = count;
                end else if (line_read_i) begin
                    state_nx = READ;
                end else if (!fifo_empty) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                dm_write_o   = 1'b1;
                dm_address_o = ADDR_W'(head_entry.addr);
                dm_data_o    = DATA_W'(head_entry.data);
                if (dm_ready_i) begin
                    pop      = 1'b1;
                    state_nx = (count > CNT_W'(1) && !line_read_i) ? WRITE : IDLE;
                end
            end
            DRAIN: begin
                dm_write_o   = 1'b1;
                dm_address_o = ADDR_W'(head_entry.addr);
                dm_data_o    = DATA_W'(head_entry.data);
                if (dm_ready_i) begin
                    pop           = 1'b1;
                    drain_left_nx = drain_left - 1'b1;
                    if (drain_left == CNT_W'(1))
                        state_nx = READ;
                end
            end
            READ: begin
                dm_read_o    = 1'b1;
                dm_address_o = line_address_i & ADDR_W'(LINE_OFF_MASK);
                if (dm_ready_i)
                    state_nx = RESP;
            end
            RESP: begin
                line_valid_o = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(wb_write_i && fifo_full && !merge_hit));

    a_read_held: assert property (@(posedge clk) disable iff (!rst)
        ((state == DRAIN) || (state == READ)) |-> line_read_i);

    a_one_dm_req: assert property (@(posedge clk) disable iff (!rst)
        !(dm_write_o && dm_read_o));

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer.
module tb_dcache_write_buffer;
    import dcache_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LW    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_write_i;
    logic [AW-1:0]     wb_address_i;
    logic [DW-1:0]     wb_data_i;
    logic              wb_full_o;
    logic              line_read_i;
    logic [AW-1:0]     line_address_i;
    logic [LW*DW-1:0]  line_data_o;
    logic              line_valid_o;
    logic              dm_write_o;
    logic              dm_read_o;
    logic [AW-1:0]     dm_address_o;
    logic [DW-1:0]     dm_data_o;
    logic [LW*DW-1:0]  dm_data_i;
    logic              dm_ready_i;

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t log_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    dcache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_write_i     (wb_write_i),
        .wb_address_i   (wb_address_i),
        .wb_data_i      (wb_data_i),
        .wb_full_o      (wb_full_o),
        .line_read_i    (line_read_i),
        .line_address_i (line_address_i),
        .line_data_o    (line_data_o),
        .line_valid_o   (line_valid_o),
        .dm_write_o     (dm_write_o),
        .dm_read_o      (dm_read_o),
        .dm_address_o   (dm_address_o),
        .dm_data_o      (dm_data_o),
        .dm_data_i      (dm_data_i),
        .dm_ready_i     (dm_ready_i)
    );

    // DM side: record every accepted transaction in order.
    always @(posedge clk) begin
        if (rst && dm_ready_i) begin
            if (dm_write_o) log_q.push_back(ev_t'{1'b0, dm_address_o, dm_data_o});
            if (dm_read_o)  log_q.push_back(ev_t'{1'b1, dm_address_o, {DW{1'b0}}});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [LW*DW-1:0] obs, input logic [LW*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_write_i   = 1'b1;
        wb_address_i = a;
        wb_data_i    = d;
        step();
        wb_write_i   = 1'b0;
    endtask

    task automatic wait_log(input int n, input string tag);
        int i = 0;
        while (log_q.size() < n && i < 50) begin
            step();
            i++;
        end
        chk(tag, log_q.size(), n);
    endtask

    function automatic ev_t wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return ev_t'{1'b0, a, d};
    endfunction

    initial begin
        logic [LW*DW-1:0] pat;
        int               got;
        int               both;

        rst = 1'b0; wb_write_i = 1'b0; wb_address_i = '0; wb_data_i = '0;
        line_read_i = 1'b0; line_address_i = '0; dm_data_i = '0; dm_ready_i = 1'b0;
        step(); step();

        // Reset state
        chk("rst_full", wb_full_o, 0);
        chk("rst_dm_write", dm_write_o, 0);
        chk("rst_dm_read", dm_read_o, 0);
        chk("rst_line_valid", line_valid_o, 0);
        chk("rst_dm_addr", dm_address_o, 0);
        chk("rst_line_data", line_data_o, 0);
        rst = 1'b1;

        // Reset while a DM write is stalled
        store(16'h0100, 32'h11);
        step();
        chk("midwr_write", dm_write_o, 1);
        chk("midwr_addr", dm_address_o, 16'h0100);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("midwr_rst_write", dm_write_o, 0);
        chk("midwr_rst_addr", dm_address_o, 0);
        chk("midwr_rst_data", dm_data_o, 0);
        chk("midwr_rst_full", wb_full_o, 0);
        chk("midwr_rst_count", dut.u_fifo.count, 0);
        store(16'h0104, 32'h22);
        chk("midwr_entry0", dut.u_fifo.mem[0].addr, 16'h0104);
        chk("midwr_tail", dut.u_fifo.tail, 1);
        dm_ready_i = 1'b1;
        wait_log(1, "midwr_nlog");
        chk("midwr_dm", log_q[0], wr(16'h0104, 32'h22));
        dm_ready_i = 1'b0;
        step(); step();
        log_q.delete();

        // Fill to full with DM stalled, then drain in order
        store(16'h0010, 32'hA0);
        store(16'h0014, 32'hA1);
        store(16'h0018, 32'hA2);
        chk("burst_full3", wb_full_o, 0);
        store(16'h001C, 32'hA3);
        chk("burst_full4", wb_full_o, 1);
        chk("burst_stalled", log_q.size(), 0);
        dm_ready_i = 1'b1;
        step();
        chk("burst_full_fall", wb_full_o, 0);
        wait_log(4, "burst_nlog");
        for (int i = 0; i < 4; i++)
            chk($sformatf("burst_wr%0d", i), log_q[i], wr(AW'(16'h10 + 4 * i), DW'(32'hA0 + i)));
        dm_ready_i = 1'b0;
        step();
        log_q.delete();

        // Refill behind a pending store
        for (int w = 0; w < LW; w++) pat[w*DW +: DW] = 32'hC0DE_0000 + DW'(w);
        dm_data_i = pat;
        store(16'h0040, 32'hDEAD);
        line_address_i = 16'h0044;
        line_read_i    = 1'b1;
        dm_ready_i     = 1'b1;
        got = 0; both = 0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            step();
            if (dm_write_o && dm_read_o) both++;
            if (line_valid_o) got = 1;
        end
        chk("rar_valid_seen", got, 1);
        chk("rar_overlap", both, 0);
        chk("rar_line", line_data_o, pat);
        line_read_i = 1'b0;
        step();
        chk("rar_valid_width", line_valid_o, 0);
        chk("rar_nlog", log_q.size(), 2);
        chk("rar_wr", log_q[0], wr(16'h0040, 32'hDEAD));
        chk("rar_rd", log_q[1], ev_t'{1'b1, 16'h0040, {DW{1'b0}}});
        dm_ready_i = 1'b0;
        log_q.delete();
        step();

        // Refill with empty buffer, DM ready immediately
        for (int w = 0; w < LW; w++) pat[w*DW +: DW] = 32'h5A00_0000 + DW'(w * 3);
        dm_data_i      = pat;
        line_address_i = 16'h1234;
        dm_ready_i     = 1'b1;
        line_read_i    = 1'b1;
        step();
        chk("ref_read_c1", dm_read_o, 1);
        chk("ref_addr", dm_address_o, 16'h1200);
        chk("ref_valid_c1", line_valid_o, 0);
        step();
        chk("ref_valid_c2", line_valid_o, 1);
        chk("ref_read_c2", dm_read_o, 0);
        chk("ref_line", line_data_o, pat);
        line_read_i = 1'b0;
        step();
        chk("ref_valid_c3", line_valid_o, 0);
        dm_ready_i = 1'b0;
        log_q.delete();

        // Push and pop together with the tail at the last slot
        rst = 1'b0;
        step();
        rst = 1'b1;
        store(16'h0200, 32'h1);
        dm_ready_i = 1'b1;
        wait_log(1, "wrap_pre_nlog");
        dm_ready_i = 1'b0;
        step();
        log_q.delete();
        store(16'h0204, 32'h2);
        store(16'h0208, 32'h3);
        chk("wrap_cnt_pre", dut.u_fifo.count, 2);
        chk("wrap_tail_pre", dut.u_fifo.tail, 3);
        chk("wrap_writing", dm_write_o, 1);
        dm_ready_i = 1'b1;
        store(16'h020C, 32'h4);
        chk("wrap_cnt_post", dut.u_fifo.count, 2);
        chk("wrap_tail_post", dut.u_fifo.tail, 0);
        chk("wrap_head_post", dut.u_fifo.head, 2);
        wait_log(3, "wrap_nlog");
        chk("wrap_wr0", log_q[0], wr(16'h0204, 32'h2));
        chk("wrap_wr1", log_q[1], wr(16'h0208, 32'h3));
        chk("wrap_wr2", log_q[2], wr(16'h020C, 32'h4));
        dm_ready_i = 1'b0;
        step();
        log_q.delete();

        // Same-address stores while DM is stalled
        store(16'h0080, 32'h1);
        store(16'h0080, 32'h2);
`ifdef DCACHE_WB_MERGE_EN
        chk("merge_count", dut.u_fifo.count, 1);
        chk("merge_head_data", dm_data_o, 32'h2);
        dm_ready_i = 1'b1;
        wait_log(1, "merge_nlog");
        step(); step(); step();
        chk("merge_single", log_q.size(), 1);
        chk("merge_wr", log_q[0], wr(16'h0080, 32'h2));
`else
        chk("nomerge_count", dut.u_fifo.count, 2);
        chk("nomerge_head_data", dm_data_o, 32'h1);
        dm_ready_i = 1'b1;
        wait_log(2, "nomerge_nlog");
        step(); step(); step();
        chk("nomerge_total", log_q.size(), 2);
        chk("nomerge_wr0", log_q[0], wr(16'h0080, 32'h1));
        chk("nomerge_wr1", log_q[1], wr(16'h0080, 32'h2));
`endif
        dm_ready_i = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
